// File: rtl/lab5_serial_pattern_gen.sv
// Serial pattern transmitter: captures a parallel pattern on start, shifts it out MSB-first
// with a valid strobe, then idles for GAP cycles. Define SEQ_GEN_LOOP_EN to enable retransmit via loop.
module lab5_serial_pattern_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic             loop,
    output logic             A,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [7:0]       frame_cnt
);

    localparam int unsigned   BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             done_q, done_d;

    logic             accept;
    logic             reload_en;
    logic [WIDTH-1:0] reload_pat;

    assign accept = (state_q == S_IDLE) && start;

`ifdef SEQ_GEN_LOOP_EN
    // Copy of the last accepted pattern; the shift register is consumed while sending.
    logic [WIDTH-1:0] pat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q <= '0;
        end else if (accept) begin
            pat_q <= pattern;
        end
    end

    assign reload_en  = loop;
    assign reload_pat = pat_q;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign reload_en   = 1'b0;
    assign reload_pat  = '0;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d   = pattern;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (GAP > 0) begin
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end else if (reload_en) begin
                        shift_d   = reload_pat;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
                if (gap_cnt_q == GAP_LAST) begin
                    if (reload_en) begin
                        shift_d   = reload_pat;
                        bit_cnt_d = '0;
                        state_d   = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
        end
    end

    // Outputs decode registered state only, so reset drives them low immediately.
    assign A         = (state_q == S_SHIFT) && shift_q[WIDTH-1];
    assign valid     = (state_q == S_SHIFT);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_lab5_serial_pattern_gen.sv
// Directed bench for lab5_serial_pattern_gen (WIDTH=8, GAP=2): vector table plus multi-cycle
// sequences for back-to-back frames, counter wrap, mid-frame reset and (if enabled) loop mode.
module tb_lab5_serial_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic       loop;
    logic       A, valid, busy, done;
    logic [7:0] frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    lab5_serial_pattern_gen #(.WIDTH(8), .GAP(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .loop      (loop),
        .A         (A),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [7:0] pattern;
        logic [3:0] exp_o;    // {A, valid, busy, done}
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {A, valid, busy, done};
    endfunction

    // Expected {A, valid, busy, done} at position p of a frame that starts at p=0 (GAP=2).
    function automatic logic [3:0] exp_outs(input logic [7:0] pat, input int p);
        logic a;
        a = (p < 8) ? pat[7 - p] : 1'b0;
        return {a, (p < 8), (p < 10), (p == 8)};
    endfunction

    initial begin
        int dones;
        int guard;

        vecs[0]  = '{1'b1, 8'hB2, 4'b1110, 8'd0};
        vecs[1]  = '{1'b0, 8'hB2, 4'b0110, 8'd0};
        vecs[2]  = '{1'b0, 8'hB2, 4'b1110, 8'd0};
        vecs[3]  = '{1'b0, 8'hB2, 4'b1110, 8'd0};
        vecs[4]  = '{1'b0, 8'hB2, 4'b0110, 8'd0};
        vecs[5]  = '{1'b0, 8'hB2, 4'b0110, 8'd0};
        vecs[6]  = '{1'b0, 8'hB2, 4'b1110, 8'd0};
        vecs[7]  = '{1'b0, 8'hB2, 4'b0110, 8'd0};
        vecs[8]  = '{1'b0, 8'hB2, 4'b0011, 8'd1};
        vecs[9]  = '{1'b0, 8'hB2, 4'b0010, 8'd1};
        vecs[10] = '{1'b0, 8'hB2, 4'b0000, 8'd1};
        vecs[11] = '{1'b0, 8'hB2, 4'b0000, 8'd1};
        vecs[12] = '{1'b1, 8'h0F, 4'b0110, 8'd1};
        vecs[13] = '{1'b0, 8'h0F, 4'b0110, 8'd1};
        vecs[14] = '{1'b1, 8'hFF, 4'b0110, 8'd1};
        vecs[15] = '{1'b0, 8'hFF, 4'b0110, 8'd1};
        vecs[16] = '{1'b0, 8'hFF, 4'b1110, 8'd1};
        vecs[17] = '{1'b0, 8'hFF, 4'b1110, 8'd1};
        vecs[18] = '{1'b0, 8'hFF, 4'b1110, 8'd1};
        vecs[19] = '{1'b0, 8'hFF, 4'b1110, 8'd1};
        vecs[20] = '{1'b0, 8'hFF, 4'b0011, 8'd2};
        vecs[21] = '{1'b0, 8'hFF, 4'b0010, 8'd2};
        vecs[22] = '{1'b0, 8'hFF, 4'b0000, 8'd2};
        vecs[23] = '{1'b0, 8'hFF, 4'b0000, 8'd2};

        // Reset, then idle for 20 cycles.
        reset   = 1'b0;
        start   = 1'b0;
        loop    = 1'b0;
        pattern = 8'h00;
        #8;
        check("reset_outs", {28'd0, outs()}, 32'd0);
        check("reset_cnt", {24'd0, frame_cnt}, 32'd0);
        #2 reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("idle_outs[%0d]", i), {28'd0, outs()}, 32'd0);
            check($sformatf("idle_cnt[%0d]", i), {24'd0, frame_cnt}, 32'd0);
        end

        // Single frame of B2, then ignored start during a 0F frame.
        for (int i = 0; i < 24; i++) begin
            start   = vecs[i].start;
            pattern = vecs[i].pattern;
            step();
            check($sformatf("vec_outs[%0d]", i), {28'd0, outs()}, {28'd0, vecs[i].exp_o});
            check($sformatf("vec_cnt[%0d]", i), {24'd0, frame_cnt}, {24'd0, vecs[i].exp_cnt});
        end

        // start held high: three A5 frames with GAP+1 idle cycles between them.
        pattern = 8'hA5;
        for (int i = 0; i <= 32; i++) begin
            start = (i <= 22);
            step();
            check($sformatf("cont[%0d]", i), {28'd0, outs()}, {28'd0, exp_outs(8'hA5, i % 11)});
        end
        check("cont_cnt", {24'd0, frame_cnt}, 32'd5);
        step();
        check("cont_idle_after", {28'd0, outs()}, 32'd0);

        // Run the counter up to 255, then one more frame wraps it to 0.
        pattern = 8'h3C;
        start   = 1'b1;
        dones   = 0;
        guard   = 0;
        while (dones < 250 && guard < 4000) begin
            step();
            guard++;
            if (done) dones++;
        end
        start = 1'b0;
        check("wrap_frames_seen", dones, 250);
        for (int i = 0; i < 4; i++) step();
        check("wrap_pre_cnt", {24'd0, frame_cnt}, 32'd255);
        check("wrap_pre_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (!done && guard < 20) begin
            step();
            guard++;
        end
        check("wrap_done_seen", {31'd0, done}, 32'd1);
        check("wrap_cnt", {24'd0, frame_cnt}, 32'd0);
        for (int i = 0; i < 3; i++) step();

        // Reset in the middle of a C3 frame.
        pattern = 8'hC3;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("midrst_before", {28'd0, outs()}, {28'd0, exp_outs(8'hC3, 3)});
        #2 reset = 1'b0;
        #1;
        check("midrst_async_outs", {28'd0, outs()}, 32'd0);
        check("midrst_async_cnt", {24'd0, frame_cnt}, 32'd0);
        step();
        step();
        check("midrst_held_outs", {28'd0, outs()}, 32'd0);
        #3 reset = 1'b1;
        step();
        check("midrst_after_release", {28'd0, outs()}, 32'd0);
        start = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            step();
            start = 1'b0;
            check($sformatf("postrst[%0d]", i), {28'd0, outs()}, {28'd0, exp_outs(8'hC3, i)});
        end
        check("postrst_cnt", {24'd0, frame_cnt}, 32'd1);

`ifdef SEQ_GEN_LOOP_EN
        // Loop mode: 96 repeats every 10 cycles until loop drops, then one last frame.
        pattern = 8'h96;
        loop    = 1'b1;
        start   = 1'b1;
        for (int i = 0; i <= 41; i++) begin
            if (i == 1) start = 1'b0;
            if (i == 33) loop = 1'b0;
            step();
            check($sformatf("loop[%0d]", i), {28'd0, outs()},
                  (i < 40) ? {28'd0, exp_outs(8'h96, i % 10)} : 32'd0);
        end
        check("loop_cnt", {24'd0, frame_cnt}, 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
